// File: rtl/alu_multicycle.sv
// Handshaked execution unit: single-cycle logic/shift/add ops plus a WIDTH-cycle shift-add multiply.
// The result and zero flag are held in registers until the downstream stage accepts them.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = ShW;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpXor = 3'b001;
  localparam logic [2:0] OpSll = 3'b010;
  localparam logic [2:0] OpAdd = 3'b011;
  localparam logic [2:0] OpSub = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpSra = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [ShW-1:0]    shamt;
  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH-1:0]  acc_step;

  assign shamt = data2_i[ShW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OpAnd:   alu_res = data1_i & data2_i;
      OpXor:   alu_res = data1_i ^ data2_i;
      OpSll:   alu_res = data1_i << shamt;
      OpAdd:   alu_res = data1_i + data2_i;
      OpSub:   alu_res = data1_i - data2_i;
      OpSra:   alu_res = $signed(data1_i) >>> shamt;
      // Reserved code, and MUL which never uses this path, yield zero.
      default: alu_res = '0;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          if (ALUCtrl_i == OpMul) begin
            acc_d    = '0;
            mcand_d  = data1_i;
            mplier_d = data2_i;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = StDone;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The WIDTH-th iteration commits its own sum straight into the result register.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          cnt_d    = '0;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;

  a_ready_valid_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_ready_q && out_valid_q));

  a_result_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_q && !out_ready_i) |=> ($stable(result_q) && $stable(zero_q) && out_valid_q));

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expected results are queued at issue and popped on output.
module tb_alu_multicycle;

  localparam int unsigned WIDTH = 32;
  localparam int MulLat = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  int n_checks;
  int n_errors;

  logic [WIDTH:0] exp_q[$];

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .ALUCtrl_i  (alu_ctrl),
    .data1_i    (data1),
    .data2_i    (data2),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .zero_o     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference; multiply uses the native operator rather than shift-add.
  function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [4:0]       sh;
    logic [WIDTH-1:0] r;
    sh = b[4:0];
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a ^ b;
      3'd2:    r = a << sh;
      3'd3:    r = a + b;
      3'd4:    r = a - b;
      3'd5:    r = a * b;
      3'd6:    r = $signed(a) >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res);
    int guard;
    in_valid = 1'b1;
    alu_ctrl = op;
    data1    = a;
    data2    = b;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 64'd0, 64'd1);
    exp_q.push_back({(exp_res == '0), exp_res});
    @(negedge clk);
    // Scramble inputs after acceptance; they must not affect the running operation.
    in_valid = 1'b0;
    alu_ctrl = 3'($urandom_range(0, 7));
    data1    = $urandom;
    data2    = $urandom;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    int busy_bad;
    logic [WIDTH:0] exp;
    lat      = 1;
    busy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_result"}, 64'(result), 64'(exp[WIDTH-1:0]));
      check({tag, "_zero"}, 64'(zero), 64'(exp[WIDTH]));
    end
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
      check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res,
                       input int exp_lat);
    issue(op, a, b, exp_res);
    wait_result(tag, exp_lat);
  endtask

  initial begin
    int stable_bad;
    int valid_bad;
    int ready_bad;
    logic [WIDTH-1:0] held;
    logic [2:0] rop;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_ctrl  = 3'd0;
    data1     = '0;
    data2     = '0;
    out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;

    do_op("add_7_5", 3'b011, 32'd7, 32'd5, 32'd12, 1);
    do_op("sub_5_5", 3'b100, 32'd5, 32'd5, 32'd0, 1);
    do_op("sub_wrap", 3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
    do_op("sll", 3'b010, 32'd1, 32'h25, 32'h20, 1);
    do_op("sra", 3'b110, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    do_op("and", 3'b000, 32'hF0F0, 32'hFF00, 32'hF000, 1);
    do_op("xor", 3'b001, 32'hFFFF, 32'h00FF, 32'hFF00, 1);
    do_op("mul_neg", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, MulLat);
    do_op("mul_wrap0", 3'b101, 32'h1_0000, 32'h1_0000, 32'd0, MulLat);
    do_op("reserved", 3'b111, 32'h1234, 32'h5678, 32'd0, 1);

    // Backpressure: result held for 10 cycles while a competing request is ignored.
    out_ready = 1'b0;
    issue(3'b011, 32'h1234, 32'h1111, 32'h2345);
    wait_result("bp", 1);
    held       = result;
    stable_bad = 0;
    valid_bad  = 0;
    ready_bad  = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      alu_ctrl = 3'b100;
      data1    = $urandom;
      data2    = $urandom;
      @(negedge clk);
      if (result !== held) stable_bad++;
      if (out_valid !== 1'b1) valid_bad++;
      if (in_ready !== 1'b0) ready_bad++;
    end
    check("bp_stable", 64'(stable_bad), 64'd0);
    check("bp_valid", 64'(valid_bad), 64'd0);
    check("bp_no_accept", 64'(ready_bad), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_valid", 64'(out_valid), 64'd0);
    check("bp_drain_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp_no_spurious", 64'(out_valid), 64'd0);

    // Reset on the edge of the 10th multiply iteration.
    issue(3'b101, 32'd123, 32'd456, 32'd56088);
    for (int i = 0; i < 9; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    void'(exp_q.pop_front());
    do_op("add_after_rst", 3'b011, 32'd2, 32'd2, 32'd4, 1);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      do_op("rand", rop, ra, rb, model(rop, ra, rb), (rop == 3'b101) ? MulLat : 1);
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execution unit on the consuming end of the 3-bit ALU control code produced by the ALU control decoder. It accepts one operation at a time through a valid/ready handshake and executes it. AND, XOR, SLL, ADD, SUB and SRA complete in one cycle. MUL is an iterative shift-add over WIDTH cycles. The result is held with a zero flag until the downstream stage acknowledges it.

## Interface
- WIDTH, 32, operand and result width. Shift amount is data2_i[$clog2(WIDTH)-1:0].
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- in_valid_i  input  1  an operation is presented.
- in_ready_o  output  1  the block can accept an operation; high only in IDLE.
- ALUCtrl_i  input  3  operation code. These values are fixed in header.v and are the same codes the decoder emits:
  - AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, SRA=110.
  - 111 is reserved.
- data1_i  input  WIDTH  operand A (rs1).
- data2_i  input  WIDTH  operand B (rs2 or immediate).
- out_valid_o  output  1  result_o and zero_o are valid.
- out_ready_i  input  1  downstream accepts the result.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  registered flag; high when result_o == 0.

## Operation
- States: IDLE, MUL, DONE.
- **IDLE**
  - in_ready_o=1.
  - On in_valid_i && in_ready_o (acceptance), ALUCtrl_i, data1_i and data2_i are captured. Input changes after acceptance have no effect.
  - Non-MUL code: the result is computed and registered; next state is DONE.
  - MUL: load the accumulator with 0, the multiplicand with data1_i, the multiplier with data2_i, and the counter with 0; next state is MUL.
- **MUL**
  - Each cycle: if multiplier[0] is set, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After the WIDTH-th iteration, result = accumulator (low WIDTH bits of the product, signed/unsigned agnostic); next state is DONE.
  - No early termination.
- **DONE**
  - out_valid_o=1. result_o and zero_o are held stable.
  - On out_ready_i, go to IDLE.
  - in_ready_o=0 in DONE, so there is no same-cycle accept-while-draining.
- Arithmetic, all mod 2^WIDTH:
  - ADD: a+b.
  - SUB: a-b.
  - AND: a&b.
  - XOR: a^b.
  - SLL: a << shamt, zero fill.
  - SRA: a >>> shamt, sign fill from a[WIDTH-1].
  - Overflow and carry are discarded.
- Reserved code 111: result 0, zero_o=1, normal DONE handshake.
- Reset values: state=IDLE, in_ready_o=1 after reset, out_valid_o=0, result_o=0, zero_o=1, counter=0, accumulator=0.
- Reset in any state aborts the operation in the same edge; no result is produced.

## Timing
- Non-MUL: accepted at edge N; out_valid_o high after edge N+1. Latency is 1 cycle.
- MUL: accepted at edge N; iterations on edges N+1..N+WIDTH; out_valid_o high after edge N+WIDTH+1. Latency is WIDTH+1 cycles (33 at default).
- Result stays valid until the first edge with out_ready_i=1. out_valid_o drops after that edge and in_ready_o rises at the same time.
- Minimum issue interval: 2 cycles for single-cycle ops, WIDTH+2 for MUL.
- in_valid_i while in_ready_o=0 is ignored. The producer must hold the operation until acceptance.
- out_ready_i asserted outside DONE has no effect.
- out_valid_o, in_ready_o, result_o and zero_o are all register outputs; there is no combinational path from inputs.

## Test plan
- Reset then ADD 7+5: assert rst_i for 2 cycles, then present ADD with a=7, b=5, and out_ready_i=1.
  - During reset: in_ready_o=1, out_valid_o=0, zero_o=1.
  - out_valid_o is high 1 cycle after acceptance with result_o=12 and zero_o=0. in_ready_o is back high the next cycle.
- SUB 5-5 and wrap: SUB with a=5, b=5 gives result 0 and zero_o=1. SUB with a=0, b=1 gives 0xFFFFFFFF and zero_o=0.
- Shifts:
  - SLL a=1, b=0x25 (shamt 5) gives 0x20.
  - SRA a=0x80000000, b=4 gives 0xF8000000.
  - AND 0xF0F0 with 0xFF00 gives 0xF000.
  - XOR 0xFFFF with 0x00FF gives 0xFF00.
- MUL: a=0xFFFFFFFF (-1), b=3.
  - in_ready_o=0 for 33 cycles.
  - out_valid_o rises exactly 33 cycles after acceptance with result_o=0xFFFFFFFD.
  - Second case: a=0x10000, b=0x10000 gives 0 with zero_o=1.
- Backpressure: hold out_ready_i=0 for 10 cycles after a result.
  - result_o must stay stable and out_valid_o must stay high.
  - in_valid_i with new operands during this time must not be accepted.
  - On out_ready_i=1 the block returns to IDLE after one edge.
- Reset mid-MUL: assert rst_i at iteration 10.
  - Next cycle: out_valid_o=0, result_o=0, in_ready_o=1.
  - A following ADD 2+2 returns 4 with normal latency.
